// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage core's pipeline control blocks.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard statistics.
module hazard_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, branch flush, memory freeze, watchdog trap.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_dst,
    input  logic       mem_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       pc_sel_branch,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic       memwb_bubble,
    output logic       err
`ifdef HAZARD_PERF_EN
    , output logic [CNT_W-1:0] load_use_cnt
    , output logic [CNT_W-1:0] mem_wait_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              memwait, loaduse, active;
    logic              ap_memwait, ap_branch, ap_loaduse;

    assign memwait = dmem_req & ~dmem_ready;
    assign loaduse = ex_memread & (ex_dst != REG_ZERO) &
                     ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));

    assign active     = (state != TRAP);
    assign ap_memwait = active & memwait;
    assign ap_branch  = active & ~memwait & mem_branch_taken;
    assign ap_loaduse = active & ~memwait & ~mem_branch_taken & loaduse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (memwait) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!memwait) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_V)) begin
                    state_nxt = TRAP;
                end else if (wait_cnt != {WAIT_W{1'b1}}) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = RUN;
        endcase
    end

    // Reset and trap share the "everything frozen and squashed" pattern; rst_n gates it asynchronously.
    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        memwb_bubble  = 1'b0;
        err           = rst_n & (state == TRAP);
        if (!rst_n || !active) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            memwb_bubble = 1'b1;
        end else if (memwait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_branch_taken) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_bubble  = 1'b1;
        end else if (loaduse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.W(CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ap_loaduse),
        .count (load_use_cnt)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_cnt_mem_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ap_memwait),
        .count (mem_wait_cnt)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ap_branch),
        .count (flush_cnt)
    );
`else
    logic unused_ap;
    assign unused_ap = ap_memwait ^ ap_branch ^ ap_loaduse;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a cycle-level model.
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rs, id_uses_rt, ex_memread, mem_branch_taken, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_sel_branch;
    logic       ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, err;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] load_use_cnt, mem_wait_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // model: length of the current uninterrupted memory wait, trap flag, event totals
    int wait_len;
    bit trapped;
    int lu_m, mw_m, fl_m;

    logic [10:0] obs;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT(MT)
`ifdef HAZARD_PERF_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .ex_memread       (ex_memread),
        .ex_dst           (ex_dst),
        .mem_branch_taken (mem_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .pc_sel_branch    (pc_sel_branch),
        .ifid_flush       (ifid_flush),
        .idex_bubble      (idex_bubble),
        .exmem_bubble     (exmem_bubble),
        .memwb_bubble     (memwb_bubble),
        .err              (err)
`ifdef HAZARD_PERF_EN
        , .load_use_cnt   (load_use_cnt)
        , .mem_wait_cnt   (mem_wait_cnt)
        , .flush_cnt      (flush_cnt)
`endif
    );

    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_sel_branch,
                  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble, err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_loaduse();
        return ex_memread && (ex_dst != 0) &&
               ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    endfunction

    function automatic bit m_memwait();
        return dmem_req && !dmem_ready;
    endfunction

    // {pc,ifid,idex,exmem,memwb enables, pc_sel_branch, ifid_flush, idex/exmem/memwb bubble, err}
    function automatic logic [10:0] model_out();
        if (!rst_n)           return 11'b00000_0_1111_0;
        if (trapped)          return 11'b00000_0_1111_1;
        if (m_memwait())      return 11'b00001_0_0001_0;
        if (mem_branch_taken) return 11'b11111_1_1110_0;
        if (m_loaduse())      return 11'b00111_0_0100_0;
        return 11'b11111_0_0000_0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        wait_len = 0;
        trapped  = 0;
        lu_m = 0;
        mw_m = 0;
        fl_m = 0;
    endtask

    task automatic model_clock();
        if (trapped) return;
        if (m_memwait())           mw_m = sat_inc(mw_m);
        else if (mem_branch_taken) fl_m = sat_inc(fl_m);
        else if (m_loaduse())      lu_m = sat_inc(lu_m);
        if (m_memwait()) begin
            wait_len++;
            if (MT != 0 && wait_len > MT) trapped = 1;
        end else begin
            wait_len = 0;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        chk(tag, 32'(obs), 32'(model_out()));
`ifdef HAZARD_PERF_EN
        chk({tag, "_lucnt"}, 32'(load_use_cnt), 32'(lu_m));
        chk({tag, "_mwcnt"}, 32'(mem_wait_cnt), 32'(mw_m));
        chk({tag, "_flcnt"}, 32'(flush_cnt), 32'(fl_m));
`endif
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_dst = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0;
        mem_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    // called just after a rising edge; the whole pulse fits before the falling edge
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk(tag, 32'(obs), 32'(11'b00000_0_1111_0));
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_outputs", 32'(obs), 32'(11'b00000_0_1111_0));
        #6;
        rst_n = 1'b1;
        step("first_normal");

        // load-use through rs, then load advances to MEM
        ex_memread = 1; ex_dst = 8; id_rs = 8; id_uses_rs = 1;
        step("lu_rs_stall");
        ex_memread = 0;
        step("lu_rs_done");
        // load-use through rt
        ex_memread = 1; ex_dst = 13; id_rt = 13; id_uses_rt = 1; id_rs = 2;
        step("lu_rt_stall");
        // register zero never stalls
        idle();
        ex_memread = 1; ex_dst = 0; id_rs = 0; id_uses_rs = 1;
        step("lu_zero");
        // matching register but not read
        ex_dst = 9; id_rs = 9; id_uses_rs = 0;
        step("lu_unused");

        // branch squashes a concurrent load-use
        idle();
        ex_memread = 1; ex_dst = 8; id_rs = 8; id_uses_rs = 1; mem_branch_taken = 1;
        step("br_over_lu");
        idle();
        step("br_done");

        // maximum wait without trap, branch held and applied on ready
        dmem_req = 1; mem_branch_taken = 1;
        repeat (MT) step("mw_frozen");
        dmem_ready = 1;
        step("mw_ready_branch");
        idle();
        step("mw_normal");

        // watchdog: trap after MT+1 wait cycles, sticky until reset
        dmem_req = 1;
        repeat (MT + 1) step("wd_wait");
        step("wd_trapped");
        dmem_ready = 1;
        step("wd_sticky");
        chk("wd_err", 32'(err), 32'(1));
        async_reset("wd_rst_async");
        idle();
        step("wd_after_rst");

        // reset mid-wait; a following full-length wait must not trap
        dmem_req = 1;
        repeat (2) step("rw_wait");
        async_reset("rw_rst_async");
        idle();
        step("rw_after_rst");
        dmem_req = 1;
        repeat (MT) step("rw_fresh_wait");
        dmem_ready = 1;
        step("rw_ready");
        idle();

        // five load-use events drive the counter into saturation
        repeat (5) begin
            ex_memread = 1; ex_dst = 5; id_rt = 5; id_uses_rt = 1;
            step("lu_sat_stall");
            idle();
            step("lu_sat_idle");
        end

        // randomized traffic, small register space to make hazards frequent
        repeat (40) begin
            async_reset("rnd_seg_rst");
            repeat (60) begin
                id_rs = 5'($urandom_range(0, 3));
                id_rt = 5'($urandom_range(0, 3));
                ex_dst = 5'($urandom_range(0, 3));
                id_uses_rs = 1'($urandom);
                id_uses_rt = 1'($urandom);
                ex_memread = 1'($urandom);
                mem_branch_taken = ($urandom_range(0, 3) == 0);
                dmem_req = 1'($urandom);
                dmem_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
                step("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
